// File: rtl/ex_stage.sv
// Execute stage: forwarding muxes, single-cycle ALU, branch resolution, and an
// optional 32-cycle shift-add multiplier compiled in with RV_EX_MUL_EN.
module ex_stage (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  input  logic        flush,
  input  logic [3:0]  alu_ctrl,
  input  logic        alu_src,
  input  logic        branch,
  input  logic        jump,
  input  logic [31:0] reg_data_1,
  input  logic [31:0] reg_data_2,
  input  logic [31:0] imm,
  input  logic [31:0] pc_add,
  input  logic [1:0]  fwd_a,
  input  logic [1:0]  fwd_b,
  input  logic [31:0] mem_fwd_data,
  input  logic [31:0] wb_fwd_data,
  output logic [31:0] alu_result,
  output logic        zero,
  output logic        branch_taken,
  output logic [31:0] target_pc,
  output logic [31:0] store_data,
  output logic        stall,
  output logic        out_valid,
  output logic [1:0]  dbg_state
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_XOR = 4'b1000;
  localparam logic [3:0] OP_SLL = 4'b1001;
  localparam logic [3:0] OP_MUL = 4'b1010;
  localparam logic [3:0] OP_SRL = 4'b1011;

  logic [31:0] op_a;
  logic [31:0] fwd_b_val;
  logic [31:0] op_b;
  logic [31:0] alu_comb;
  logic [31:0] result_int;
  logic        stall_int;
  logic        out_valid_int;
  logic        is_mul;

  // Code 11 on either select falls back to the register-file value.
  always_comb begin
    case (fwd_a)
      2'b01:   op_a = wb_fwd_data;
      2'b10:   op_a = mem_fwd_data;
      default: op_a = reg_data_1;
    endcase
    case (fwd_b)
      2'b01:   fwd_b_val = wb_fwd_data;
      2'b10:   fwd_b_val = mem_fwd_data;
      default: fwd_b_val = reg_data_2;
    endcase
  end

  assign op_b       = alu_src ? imm : fwd_b_val;
  assign store_data = fwd_b_val;
  assign is_mul     = (alu_ctrl == OP_MUL);

  // MUL is not handled here; its combinational value is 0.
  always_comb begin
    alu_comb = 32'd0;
    case (alu_ctrl)
      OP_AND:  alu_comb = op_a & op_b;
      OP_OR:   alu_comb = op_a | op_b;
      OP_ADD:  alu_comb = op_a + op_b;
      OP_SUB:  alu_comb = op_a - op_b;
      OP_SLT:  alu_comb = {31'd0, ($signed(op_a) < $signed(op_b))};
      OP_XOR:  alu_comb = op_a ^ op_b;
      OP_SLL:  alu_comb = op_a << op_b[4:0];
      OP_SRL:  alu_comb = op_a >> op_b[4:0];
      default: alu_comb = 32'd0;
    endcase
  end

`ifdef RV_EX_MUL_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mul_state_t;

  mul_state_t  state, state_nxt;
  logic [4:0]  cnt;
  logic [31:0] mcand;
  logic [31:0] mplier;
  logic [31:0] prod;
  logic        accept;

  assign accept = (state == IDLE) && in_valid && is_mul && !flush;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state  <= IDLE;
      cnt    <= 5'd0;
      mcand  <= 32'd0;
      mplier <= 32'd0;
      prod   <= 32'd0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        mcand  <= op_a;
        mplier <= op_b;
        prod   <= 32'd0;
        cnt    <= 5'd0;
      end else if (state == BUSY) begin
        prod   <= prod + (mplier[0] ? mcand : 32'd0);
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + 5'd1;
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    stall_int     = 1'b0;
    out_valid_int = 1'b0;
    result_int    = alu_comb;
    case (state)
      IDLE: begin
        stall_int     = accept;
        out_valid_int = in_valid && !flush && !is_mul;
        if (accept) state_nxt = BUSY;
      end
      BUSY: begin
        stall_int = !flush;
        if (flush)              state_nxt = IDLE;
        else if (cnt == 5'd31)  state_nxt = DONE;
      end
      DONE: begin
        result_int    = prod;
        out_valid_int = !flush;
        state_nxt     = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign dbg_state = state;
`else
  logic unused_clk;
  assign unused_clk    = clk ^ is_mul;
  assign stall_int     = 1'b0;
  assign out_valid_int = in_valid && !flush;
  assign result_int    = alu_comb;
  assign dbg_state     = 2'd0;
`endif

  // Reset masks the handshake outputs so nothing leaks while rstn is low.
  assign alu_result   = result_int;
  assign zero         = (result_int == 32'd0);
  assign stall        = rstn && stall_int;
  assign out_valid    = rstn && out_valid_int;
  assign branch_taken = rstn && in_valid && !flush && !stall_int &&
                        (jump || (branch && zero));
  assign target_pc    = pc_add;

endmodule

// File: tb/tb_ex_stage.sv
// Randomized bench for ex_stage with a behavioural reference model; covers the
// multiplier sequence when RV_EX_MUL_EN is defined.
`timescale 1ns/1ps
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid, flush, alu_src, branch, jump;
  logic [3:0]  alu_ctrl;
  logic [31:0] reg_data_1, reg_data_2, imm, pc_add, mem_fwd_data, wb_fwd_data;
  logic [1:0]  fwd_a, fwd_b;
  logic [31:0] alu_result, target_pc, store_data;
  logic        zero, branch_taken, stall, out_valid;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  ex_stage dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .flush(flush),
    .alu_ctrl(alu_ctrl), .alu_src(alu_src), .branch(branch), .jump(jump),
    .reg_data_1(reg_data_1), .reg_data_2(reg_data_2), .imm(imm),
    .pc_add(pc_add), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .mem_fwd_data(mem_fwd_data), .wb_fwd_data(wb_fwd_data),
    .alu_result(alu_result), .zero(zero), .branch_taken(branch_taken),
    .target_pc(target_pc), .store_data(store_data), .stall(stall),
    .out_valid(out_valid), .dbg_state(dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] r,
                                       input logic [31:0] wb, input logic [31:0] mem);
    if (sel == 2'd1) return wb;
    if (sel == 2'd2) return mem;
    return r;
  endfunction

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] p;
    case (op)
      4'd0:  return a & b;
      4'd1:  return a | b;
      4'd2:  return a + b;
      4'd6:  return a - b;
      4'd7:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd8:  return a ^ b;
      4'd9:  return a << b[4:0];
      4'd11: return a >> b[4:0];
      4'd10: begin
`ifdef RV_EX_MUL_EN
        p = {32'd0, a} * {32'd0, b};
        return p[31:0];
`else
        p = 64'd0;
        return p[31:0];
`endif
      end
      default: return 32'd0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; flush = 0; alu_src = 0; branch = 0; jump = 0;
    alu_ctrl = 4'd0; fwd_a = 2'd0; fwd_b = 2'd0;
    reg_data_1 = 0; reg_data_2 = 0; imm = 0; pc_add = 0;
    mem_fwd_data = 0; wb_fwd_data = 0;
  endtask

  // Checks a single-cycle instruction already driven on the inputs.
  task automatic check_alu(input string tag);
    logic [31:0] a, sb, b, r, got;
    logic        bt;
    a  = pick(fwd_a, reg_data_1, wb_fwd_data, mem_fwd_data);
    sb = pick(fwd_b, reg_data_2, wb_fwd_data, mem_fwd_data);
    b  = alu_src ? imm : sb;
    r  = ref_alu(alu_ctrl, a, b);
    bt = in_valid && !flush && (jump || (branch && (r == 32'd0)));
    exp_q.push_back(r);
    @(negedge clk);
    got = exp_q.pop_front();
    check({tag, "_res"}, alu_result, got);
    check({tag, "_zero"}, zero, (got == 32'd0));
    check({tag, "_sdata"}, store_data, sb);
    check({tag, "_ovalid"}, out_valid, in_valid && !flush);
    check({tag, "_stall"}, stall, 0);
    check({tag, "_btaken"}, branch_taken, bt);
    check({tag, "_tpc"}, target_pc, pc_add);
  endtask

  // Issues a MUL held in ID/EX while stalled; forward selects are scrambled
  // during the stall to confirm operands were captured at accept.
  task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input string tag);
    int n_stall = 0;
    int bad_ov  = 0;
    idle_inputs();
    in_valid = 1; alu_ctrl = 4'b1010; reg_data_1 = a; reg_data_2 = b;
    exp_q.push_back(ref_alu(4'b1010, a, b));
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!stall) break;
      n_stall++;
      if (out_valid) bad_ov++;
      tick();
      fwd_a = 2'($urandom_range(0, 3));
      fwd_b = 2'($urandom_range(0, 3));
      mem_fwd_data = $urandom;
      wb_fwd_data  = $urandom;
    end
`ifdef RV_EX_MUL_EN
    check({tag, "_stall_cycles"}, n_stall, 33);
`else
    check({tag, "_stall_cycles"}, n_stall, 0);
`endif
    check({tag, "_busy_ovalid"}, bad_ov, 0);
    check({tag, "_res"}, alu_result, exp_q.pop_front());
    check({tag, "_ovalid"}, out_valid, 1);
    tick();
    idle_inputs();
    @(negedge clk);
    check({tag, "_ovalid_drop"}, out_valid, 0);
    tick();
  endtask

  initial begin
    int ov_seen;
    idle_inputs();
    rstn = 0;
    in_valid = 1; jump = 1; alu_ctrl = 4'b1010;
    tick(); tick(); tick();
    @(negedge clk);
    check("rst_stall", stall, 0);
    check("rst_ovalid", out_valid, 0);
    check("rst_btaken", branch_taken, 0);
    tick();
    rstn = 1;
    idle_inputs();
    @(negedge clk);
    check("post_rst_stall", stall, 0);
    check("post_rst_ovalid", out_valid, 0);
    tick();

    in_valid = 1; alu_ctrl = 4'b0010; reg_data_1 = 5; imm = 7; alu_src = 1;
    check_alu("add_imm");
    check("add_imm_12", alu_result, 32'd12);
    tick();

    idle_inputs();
    in_valid = 1; alu_ctrl = 4'b0110; fwd_a = 2'd2; mem_fwd_data = 9;
    reg_data_1 = 32'hdead; reg_data_2 = 9; branch = 1; pc_add = 32'h0000_4000;
    check_alu("sub_br");
    check("sub_br_taken", branch_taken, 1);
    tick();

    for (int i = 0; i < 150; i++) begin
      idle_inputs();
      in_valid = ($urandom_range(0, 7) != 0);
      flush    = ($urandom_range(0, 7) == 0);
      alu_ctrl = 4'($urandom_range(0, 15));
`ifdef RV_EX_MUL_EN
      if (alu_ctrl == 4'b1010) alu_ctrl = 4'b0110;
`endif
      alu_src = 1'($urandom_range(0, 1));
      branch  = 1'($urandom_range(0, 1));
      jump    = ($urandom_range(0, 5) == 0);
      fwd_a   = 2'($urandom_range(0, 3));
      fwd_b   = 2'($urandom_range(0, 3));
      reg_data_1 = $urandom; imm = $urandom; pc_add = $urandom;
      mem_fwd_data = $urandom; wb_fwd_data = $urandom;
      reg_data_2 = ($urandom_range(0, 3) == 0) ? reg_data_1 : $urandom;
      if ($urandom_range(0, 3) == 0) imm = 32'($urandom_range(0, 40));
      check_alu("rand");
      tick();
    end

    run_mul(32'h0001_0003, 32'h0000_0005, "mul_a");
    run_mul(32'hffff_ffff, 32'hffff_ffff, "mul_ff");
    run_mul(32'd3, 32'd4, "mul_3x4");
    for (int i = 0; i < 3; i++) run_mul($urandom, $urandom, "mul_rand");

    // A flush arriving with the MUL accept wins; no multiply starts.
    idle_inputs();
    in_valid = 1; alu_ctrl = 4'b1010; flush = 1; reg_data_1 = 7; reg_data_2 = 9;
    @(negedge clk);
    check("fl_acc_stall", stall, 0);
    check("fl_acc_ovalid", out_valid, 0);
    tick();
    idle_inputs();
    @(negedge clk);
    check("fl_acc_idle", stall, 0);
    tick();

`ifdef RV_EX_MUL_EN
    idle_inputs();
    in_valid = 1; alu_ctrl = 4'b1010; reg_data_1 = 32'h1234; reg_data_2 = 32'h55;
    for (int i = 0; i < 11; i++) tick();
    flush = 1;
    @(negedge clk);
    check("fl_busy_stall", stall, 0);
    check("fl_busy_ovalid", out_valid, 0);
    tick();
    idle_inputs();
    ov_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid || stall) ov_seen++;
      tick();
    end
    check("fl_busy_quiet", ov_seen, 0);
    in_valid = 1; alu_ctrl = 4'b0010; reg_data_1 = 100; reg_data_2 = 23;
    check_alu("fl_add");
    tick();
    run_mul(32'd6, 32'd7, "fl_mul");

    idle_inputs();
    in_valid = 1; alu_ctrl = 4'b1010; reg_data_1 = 32'h77; reg_data_2 = 32'h3;
    for (int i = 0; i < 6; i++) tick();
    rstn = 0;
    tick();
    @(negedge clk);
    check("rst_busy_stall", stall, 0);
    check("rst_busy_ovalid", out_valid, 0);
    tick();
    rstn = 1;
    idle_inputs();
    ov_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid || stall) ov_seen++;
      tick();
    end
    check("rst_busy_quiet", ov_seen, 0);
    run_mul(32'd11, 32'd13, "rst_mul");
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 The block SHALL use reset rstn, synchronous, active-low; clock clk.
REQ-002 Ports SHALL be as follows; all data inputs come from the ID/EX pipeline register:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- in_valid  in  1  ID/EX holds a valid instruction
- flush  in  1  kill the current instruction, abort any multiply
- alu_ctrl  in  4  operation select
- alu_src  in  1  operand B source: 1=imm, 0=register
- branch  in  1  conditional-branch instruction
- jump  in  1  unconditional jump
- reg_data_1  in  32  Rs1 value from the register file
- reg_data_2  in  32  Rs2 value from the register file
- imm  in  32  immediate
- pc_add  in  32  precomputed branch/jump target
- fwd_a  in  2  operand A forward select: 00=reg, 01=WB, 10=MEM
- fwd_b  in  2  operand B forward select, same encoding
- mem_fwd_data  in  32  EX/MEM result
- wb_fwd_data  in  32  writeback value
- alu_result  out  32  result
- zero  out  1  alu_result==0
- branch_taken  out  1  redirect fetch
- target_pc  out  32  redirect address
- store_data  out  32  forwarded operand B before the imm mux
- stall  out  1  hold the ID/EX and earlier stages (drives their en low)
- out_valid  out  1  result valid this cycle

Function
REQ-003 Operand A SHALL be selected by fwd_a; fwd_b=11 and fwd_a=11 SHALL select the register value.
REQ-004 Operand B SHALL be the fwd_b-selected value when alu_src=0, else imm; store_data SHALL always be the fwd_b-selected value.
REQ-005 alu_ctrl encodings SHALL be:
- 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed), 1000 XOR
- 1001 SLL by B[4:0], 1011 SRL by B[4:0]
- 1010 MUL, returning the low 32 bits of an unsigned product
- any other code returns 0
REQ-006 Non-MUL operations SHALL be combinational with zero latency; stall=0; out_valid=in_valid&~flush.
REQ-007 branch_taken SHALL equal in_valid&~flush&~stall&(jump|(branch&zero)); target_pc SHALL equal pc_add.
REQ-008 MUL SHALL use a sequential FSM with states IDLE, BUSY and DONE.
REQ-009 IDLE + in_valid + MUL + ~flush: stall=1 combinationally; load the multiplicand and multiplier; counter=0; next state BUSY.
REQ-010 BUSY: perform one shift-add step per cycle for 32 cycles, counter 0..31; stall=1; out_valid=0; when counter=31, next state DONE.
REQ-011 DONE: alu_result=product register; stall=0; out_valid=1; next state IDLE. Total stall is 33 cycles, from the accept cycle through the last BUSY cycle.
REQ-012 Operands SHALL be captured at accept; forward-select changes during BUSY SHALL be ignored.
REQ-013 flush in BUSY or DONE SHALL return the FSM to IDLE on the next edge; stall SHALL drop combinationally; out_valid=0.
REQ-014 flush and a MUL accept in the same cycle: the flush SHALL win, and the FSM SHALL stay in IDLE.
REQ-015 The counter SHALL be 5 bits; wrap from 31 is never used because the transition to DONE occurs first.

Reset
REQ-016 When rstn=0 at a clk edge:
- FSM=IDLE
- counter=0
- product and operand registers=0
REQ-017 During and after reset:
- stall=0
- out_valid=0
- branch_taken=0
REQ-018 Reset mid-multiply SHALL discard the multiply; no result SHALL be produced.

Configuration
REQ-019 Macro RV_EX_MUL_EN SHALL compile in the FSM, counter, and product/operand registers.
REQ-020 Without RV_EX_MUL_EN, alu_ctrl=1010 SHALL return 0 combinationally; stall SHALL be tied to 0; the block SHALL contain no sequential logic.

Verification
REQ-021 ADD with reg_data_1=5, imm=7, alu_src=1, fwd=00 -> alu_result=12, zero=0, stall=0, same cycle.
REQ-022 SUB with fwd_a=10, mem_fwd_data=9, reg_data_2=9, branch=1 -> zero=1, branch_taken=1, target_pc=pc_add.
REQ-023 MUL 0x0001_0003 * 0x0000_0005 (RV_EX_MUL_EN defined):
- stall high for exactly 33 cycles
- on the next cycle: alu_result=0x0005_000F, out_valid=1 for 1 cycle
REQ-024 MUL 0xFFFF_FFFF * 0xFFFF_FFFF -> alu_result=0x0000_0001.
REQ-025 MUL flush at BUSY cycle 10 -> next cycle FSM=IDLE, stall=0, no out_valid pulse; a following ADD completes normally.
REQ-026 rstn=0 at BUSY cycle 5 -> stall=0 after the edge; with RV_EX_MUL_EN undefined, MUL 3*4 -> alu_result=0, stall never 1.
